input_port_buffer: RTL and testbench

INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

---
 rtl/input_port_buffer.sv | 113 +++++++++++
 tb/tb_input_port_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/input_port_buffer.sv
// Router input port: parses incoming flits into well-formed packets and buffers them in a FIFO.
// The FIFO head is presented to the arbiter, and the head flit is popped toward the crossbar on grant.
module input_port_buffer #(
    parameter int DEPTH  = 8,
    parameter int FLIT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    localparam logic [2:0] ID_HEAD = 3'b001;
    localparam logic [2:0] ID_BODY = 3'b010;
    localparam logic [2:0] ID_TAIL = 3'b100;

    localparam logic [0:0] EXPECT_HEAD = 1'b0;
    localparam logic [0:0] IN_PKT      = 1'b1;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [0:0]        state, state_next;
    logic [11:0]       len_q;

    logic              accept, push, pop, head_is_hdr;
    logic [2:0]        in_id;
    logic [FLIT_W-1:0] head;

    assign in_ready = (count != FULL_COUNT);
    assign req      = (count != '0);
    assign accept   = in_valid && in_ready;
    assign pop      = grant && (count != '0);
    assign in_id    = in_flit[FLIT_W-1:FLIT_W-3];
    assign head     = mem[rd_ptr];

    assign flit_id     = (count != '0) ? head[FLIT_W-1:FLIT_W-3] : 3'b000;
    assign head_is_hdr = (flit_id == ID_HEAD);
    assign length      = head_is_hdr ? head[11:0] : len_q;

    // Discarded flits still complete the handshake (accept) but are never pushed.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        push       = 1'b0;
        state_next = state;
        if (accept) begin
            if (state == EXPECT_HEAD) begin
                if (in_id == ID_HEAD) begin
                    push       = 1'b1;
                    state_next = IN_PKT;
                end
            end else begin
                if (in_id == ID_BODY) begin
                    push = 1'b1;
                end else if (in_id == ID_TAIL) begin
                    push       = 1'b1;
                    state_next = EXPECT_HEAD;
                end
            end
        end
    end

    // NOTE: the flit storage has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= EXPECT_HEAD;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            drop_err  <= 1'b0;
        end else begin
            state    <= state_next;
            drop_err <= accept && !push;
            out_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                out_flit <= head;
                if (head_is_hdr) begin
                    len_q <= head[11:0];
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer (DEPTH=8, FLIT_W=32) with hand-computed expectations.
module tb_input_port_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_flit;
    logic        in_ready;
    logic        grant;
    logic        req;
    logic [2:0]  flit_id;
    logic [11:0] length;
    logic        out_valid;
    logic [31:0] out_flit;
    logic        drop_err;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] HD = 3'b001;
    localparam logic [2:0] BD = 3'b010;
    localparam logic [2:0] TL = 3'b100;

    input_port_buffer #(.DEPTH(8), .FLIT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
        .grant(grant), .req(req), .flit_id(flit_id), .length(length),
        .out_valid(out_valid), .out_flit(out_flit), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] id, input logic [11:0] low);
        return {id, 17'b0, low};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] f);
        in_valid = 1'b1;
        in_flit  = f;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        grant = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Hold grant for n cycles and expect flits exp[0..n-1] on consecutive cycles.
    task automatic drain(input string tag, input logic [31:0] exp [$], input logic [11:0] len_exp);
        grant = 1'b1;
        foreach (exp[i]) begin
            tick();
            check({tag, "_ov"}, 32'(out_valid), 1);
            check({tag, "_flit"}, out_flit, exp[i]);
            if (len_exp != 12'd0) check({tag, "_len"}, 32'(length), 32'(len_exp));
        end
        grant = 1'b0;
        tick();
        check({tag, "_ov_end"}, 32'(out_valid), 0);
        check({tag, "_req_end"}, 32'(req), 0);
    endtask

    initial begin
        logic [31:0] q [$];
        in_flit = '0;

        // Reset state
        do_reset();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_req", 32'(req), 0);
        check("rst_flit_id", 32'(flit_id), 0);
        check("rst_length", 32'(length), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_drop", 32'(drop_err), 0);

        // Header/body/tail with grant held
        grant = 1'b1;
        push(mk(HD, 12'd3));
        check("p1_req", 32'(req), 1);
        check("p1_id", 32'(flit_id), 32'(HD));
        check("p1_len", 32'(length), 3);
        check("p1_ov0", 32'(out_valid), 0);
        push(mk(BD, 12'hB01));
        check("p1_o0", out_flit, mk(HD, 12'd3));
        check("p1_ov1", 32'(out_valid), 1);
        check("p1_len1", 32'(length), 3);
        push(mk(TL, 12'hE01));
        check("p1_o1", out_flit, mk(BD, 12'hB01));
        check("p1_len2", 32'(length), 3);
        tick();
        check("p1_o2", out_flit, mk(TL, 12'hE01));
        check("p1_ov2", 32'(out_valid), 1);
        check("p1_req_end", 32'(req), 0);
        check("p1_len3", 32'(length), 3);
        grant = 1'b0;
        tick();
        check("p1_ov_end", 32'(out_valid), 0);
        check("p1_hold", out_flit, mk(TL, 12'hE01));

        // Body first after reset is dropped
        do_reset();
        push(mk(BD, 12'h111));
        check("bf_drop", 32'(drop_err), 1);
        check("bf_req", 32'(req), 0);
        tick();
        check("bf_drop_pulse", 32'(drop_err), 0);
        push(mk(HD, 12'd2));
        check("bf_hdr_req", 32'(req), 1);
        check("bf_hdr_drop", 32'(drop_err), 0);
        push(mk(TL, 12'h222));
        q = '{mk(HD, 12'd2), mk(TL, 12'h222)};
        drain("bf", q, 12'd2);

        // Header inside packet is dropped, tail still accepted
        do_reset();
        push(mk(HD, 12'd3));
        push(mk(BD, 12'h333));
        push(mk(HD, 12'd7));
        check("hi_drop", 32'(drop_err), 1);
        push(mk(TL, 12'h444));
        check("hi_drop_clr", 32'(drop_err), 0);
        check("hi_len", 32'(length), 3);
        q = '{mk(HD, 12'd3), mk(BD, 12'h333), mk(TL, 12'h444)};
        drain("hi", q, 12'd3);

        // Fill to full, blocked push, pop at full
        do_reset();
        push(mk(HD, 12'd8));
        for (int i = 1; i < 7; i++) push(mk(BD, 12'(i)));
        check("fl_ready7", 32'(in_ready), 1);
        push(mk(TL, 12'hFFF));
        check("fl_ready8", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_flit  = mk(HD, 12'd1);
        tick();
        check("fl_held_ready", 32'(in_ready), 0);
        check("fl_held_ov", 32'(out_valid), 0);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        check("fl_pop_ov", 32'(out_valid), 1);
        check("fl_pop_flit", out_flit, mk(HD, 12'd8));
        check("fl_pop_ready", 32'(in_ready), 1);
        check("fl_pop_drop", 32'(drop_err), 0);
        tick();
        in_valid = 1'b0;
        check("fl_refill_ready", 32'(in_ready), 0);
        q = {};
        for (int i = 1; i < 7; i++) q.push_back(mk(BD, 12'(i)));
        q.push_back(mk(TL, 12'hFFF));
        q.push_back(mk(HD, 12'd1));
        drain("fl", q, 12'd0);

        // Grant withdrawn mid-packet and re-granted
        do_reset();
        push(mk(HD, 12'd5));
        push(mk(BD, 12'h501));
        push(mk(BD, 12'h502));
        push(mk(BD, 12'h503));
        push(mk(TL, 12'h504));
        q = '{mk(HD, 12'd5), mk(BD, 12'h501)};
        grant = 1'b1;
        foreach (q[i]) begin
            tick();
            check("gt_first", out_flit, q[i]);
        end
        grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("gt_idle_ov", 32'(out_valid), 0);
            check("gt_idle_len", 32'(length), 5);
        end
        check("gt_idle_id", 32'(flit_id), 32'(BD));
        q = '{mk(BD, 12'h502), mk(BD, 12'h503), mk(TL, 12'h504)};
        drain("gt", q, 12'd5);

        // Reset with flits stored
        do_reset();
        push(mk(HD, 12'd5));
        for (int i = 0; i < 3; i++) push(mk(BD, 12'(i)));
        push(mk(TL, 12'h0));
        grant = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        grant = 1'b0;
        check("mr_req", 32'(req), 0);
        check("mr_ready", 32'(in_ready), 1);
        check("mr_ov", 32'(out_valid), 0);
        check("mr_id", 32'(flit_id), 0);
        check("mr_len", 32'(length), 0);
        check("mr_flit", out_flit, 0);
        push(mk(HD, 12'd8));
        for (int i = 0; i < 6; i++) push(mk(BD, 12'(i)));
        check("mr_ready7", 32'(in_ready), 1);
        push(mk(TL, 12'h0));
        check("mr_ready8", 32'(in_ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
